// File: rtl/debug_controller.sv
// rtl/debug_controller.sv - debug execution sequencer: decodes UART command bytes,
// gates/resets the core and sequences the state-dump handshake.
module debug_controller #(
    parameter logic [7:0]  CMD_RUN        = 8'h52,
    parameter logic [7:0]  CMD_STEP       = 8'h53,
    parameter logic [7:0]  CMD_STOP       = 8'h48,
    parameter logic [7:0]  CMD_RESET      = 8'h58,
    parameter int          RST_CYCLES     = 4,
    parameter logic [31:0] MAX_RUN_CYCLES = 32'd1_000_000
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic [7:0]  rx_data_i,
    input  logic        rx_valid_i,
    output logic        core_en_o,
    output logic        core_rst_o,
    input  logic        core_halt_i,
    output logic        dump_trigger_o,
    output logic        dump_mem_mode_o,
    input  logic        dump_done_i,
    output logic        busy_o,
    output logic        halted_o,
    output logic        timeout_o,
    output logic [31:0] cycle_count_o
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RUN,
        S_STEP,
        S_DUMP,
        S_DUMP_RELEASE,
        S_CORE_RST
    } state_t;

    localparam int RCW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

    state_t          state;
    logic [31:0]     cycle_count;
    logic [31:0]     watchdog;
    logic [RCW-1:0]  rst_cnt;
    logic            halted;
    logic            timeout;
    logic            mem_mode;

    logic            stop_req;
    logic            wd_expire;

    assign stop_req  = rx_valid_i && (rx_data_i == CMD_STOP);
    assign wd_expire = (watchdog == MAX_RUN_CYCLES - 32'd1);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state       <= S_IDLE;
            cycle_count <= 32'd0;
            watchdog    <= 32'd0;
            rst_cnt     <= '0;
            halted      <= 1'b0;
            timeout     <= 1'b0;
            mem_mode    <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (rx_valid_i) begin
                        if (rx_data_i == CMD_RUN && !halted) begin
                            state    <= S_RUN;
                            mem_mode <= 1'b1;
                            watchdog <= 32'd0;
                        end else if (rx_data_i == CMD_STEP && !halted) begin
                            state    <= S_STEP;
                            mem_mode <= 1'b0;
                        end else if (rx_data_i == CMD_RESET) begin
                            state       <= S_CORE_RST;
                            rst_cnt     <= RCW'(RST_CYCLES - 1);
                            halted      <= 1'b0;
                            timeout     <= 1'b0;
                            cycle_count <= 32'd0;
                            watchdog    <= 32'd0;
                        end
                    end
                end
                S_STEP: begin
                    cycle_count <= cycle_count + 32'd1;
                    if (core_halt_i) begin
                        halted <= 1'b1;
                    end
                    state <= S_DUMP;
                end
                S_RUN: begin
                    cycle_count <= cycle_count + 32'd1;
                    watchdog    <= watchdog + 32'd1;
                    // Every termination cause is latched, even when several coincide.
                    if (core_halt_i) begin
                        halted <= 1'b1;
                    end
                    if (wd_expire) begin
                        timeout <= 1'b1;
                    end
                    if (core_halt_i || stop_req || wd_expire) begin
                        state <= S_DUMP;
                    end
                end
                S_DUMP: begin
                    if (dump_done_i) begin
                        state <= S_DUMP_RELEASE;
                    end
                end
                S_DUMP_RELEASE: begin
                    // Wait for done to fall so a stale level cannot retrigger a dump.
                    if (!dump_done_i) begin
                        state <= S_IDLE;
                    end
                end
                S_CORE_RST: begin
                    if (rst_cnt == '0) begin
                        state <= S_IDLE;
                    end else begin
                        rst_cnt <= rst_cnt - 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign core_en_o       = (state == S_RUN) || (state == S_STEP);
    assign core_rst_o      = (state == S_CORE_RST);
    assign dump_trigger_o  = (state == S_DUMP);
    assign busy_o          = (state != S_IDLE);
    assign dump_mem_mode_o = mem_mode;
    assign halted_o        = halted;
    assign timeout_o       = timeout;
    assign cycle_count_o   = cycle_count;

endmodule
